// File: rtl/responder_pkg.sv
// Shared definitions for the responder front end: debounce state encoding and
// the stable-time-to-cycles conversion used to size the debounce counters.
package responder_pkg;

  typedef enum logic [1:0] {
    REL   = 2'd0,
    CHK_P = 2'd1,
    PRS   = 2'd2,
    CHK_R = 2'd3
  } db_state_e;

  function automatic int db_cycles_calc(input int clk_freq_hz, input int debounce_ms);
    return clk_freq_hz / 1000 * debounce_ms;
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Button bundle between the pins and the responder: raw pins in, clean
// levels and one-cycle press/release pulses out.
interface key_debounce_if #(
  parameter int NUM_KEYS = 6
);

  logic [NUM_KEYS-1:0] Key_Raw;
  logic [NUM_KEYS-1:0] Key_Level;
  logic [NUM_KEYS-1:0] Key_Press;
  logic [NUM_KEYS-1:0] Key_Release;

  modport master (
    output Key_Raw,
    input  Key_Level,
    input  Key_Press,
    input  Key_Release
  );

  modport slave (
    input  Key_Raw,
    output Key_Level,
    output Key_Press,
    output Key_Release
  );

endinterface

// File: rtl/key_debounce_channel.sv
// One button channel: 2-flop synchroniser, REL/CHK_P/PRS/CHK_R FSM and a
// saturating stability counter. Input is already normalised (1 = pressed).
module key_debounce_channel
  import responder_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int CW        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_pressed,
  output logic level_o,
  output logic press_o,
  output logic rel_o
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES);

  logic          sync1_q, sync2_q;
  logic          p;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  // Reset value 0 is the released level, i.e. the inactive pin after normalisation
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_pressed;
      sync2_q <= sync1_q;
    end
  end

  assign p = sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REL;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Any reversal while checking drops back to the stable state with no credit kept
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      REL: begin
        if (p) begin
          state_d = CHK_P;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_P: begin
        if (!p) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRS: begin
        if (!p) begin
          state_d = CHK_R;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_R: begin
        if (p) begin
          state_d = PRS;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_comb begin
    press_d = (state_q == CHK_P) &&  p && (cnt_q == CNT_MAX);
    rel_d   = (state_q == CHK_R) && !p && (cnt_q == CNT_MAX);
    level_d = level_q;
    if (press_d) level_d = 1'b1;
    if (rel_d)   level_d = 1'b0;
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces NUM_KEYS independent push buttons into CLK; bit map at the
// responder is [3:0] = K1..K4, [4] = Start, [5] = Answer.
module key_debounce
  import responder_pkg::*;
#(
  parameter int NUM_KEYS    = 6,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic           CLK,
  input  logic           RST,
  key_debounce_if.slave  kb
);

  localparam int DB_CYCLES = db_cycles_calc(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int CW        = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);

  if (DB_CYCLES < 1) begin : g_param_err
    $error("key_debounce: DB_CYCLES must be >= 1");
  end

  logic [NUM_KEYS-1:0] raw_norm;
  logic [NUM_KEYS-1:0] level_w;
  logic [NUM_KEYS-1:0] press_w;
  logic [NUM_KEYS-1:0] rel_w;

  assign raw_norm = (ACTIVE_LOW != 0) ? ~kb.Key_Raw : kb.Key_Raw;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_channel #(
      .DB_CYCLES (DB_CYCLES),
      .CW        (CW)
    ) u_ch (
      .clk         (CLK),
      .rst         (RST),
      .raw_pressed (raw_norm[i]),
      .level_o     (level_w[i]),
      .press_o     (press_w[i]),
      .rel_o       (rel_w[i])
    );
  end

  assign kb.Key_Level   = level_w;
  assign kb.Key_Press   = press_w;
  assign kb.Key_Release = rel_w;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES = 4, active-low pins, 6 keys.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  key_debounce_if #(.NUM_KEYS(6)) kb ();

  key_debounce #(
    .NUM_KEYS    (6),
    .CLK_FREQ_HZ (1000),
    .DEBOUNCE_MS (4),
    .ACTIVE_LOW  (1)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .kb  (kb)
  );

  always #5 clk = ~clk;

  // Drive raw pins, let one edge sample them, then compare {level, press, release}
  task automatic cyc(input string tag, input int idx, input logic [5:0] raw,
                     input logic [5:0] e_lvl, input logic [5:0] e_prs, input logic [5:0] e_rel);
    logic [17:0] obs;
    logic [17:0] exp_v;
    kb.Key_Raw = raw;
    @(posedge clk);
    #1;
    obs   = {kb.Key_Level, kb.Key_Press, kb.Key_Release};
    exp_v = {e_lvl, e_prs, e_rel};
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s[%0d] lvl/prs/rel observed=%h expected=%h", tag, idx, obs, exp_v);
    end
  endtask

  initial begin
    kb.Key_Raw = 6'h3F;

    // 1: reset with all pins idle, then idle after reset
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc("rst", i, 6'h3F, 6'h00, 6'h00, 6'h00);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc("post_rst", i, 6'h3F, 6'h00, 6'h00, 6'h00);

    // 2: key 0 pressed 12 cycles -> press at sampling edge index 6, then released
    for (int i = 0; i < 12; i++)
      cyc("k0_press", i, 6'h3E, (i >= 6) ? 6'h01 : 6'h00, (i == 6) ? 6'h01 : 6'h00, 6'h00);
    for (int i = 0; i < 12; i++)
      cyc("k0_rel", i, 6'h3F, (i >= 6) ? 6'h00 : 6'h01, 6'h00, (i == 6) ? 6'h01 : 6'h00);

    // 3a: key 2 low for 3 samples -> rejected
    for (int i = 0; i < 12; i++)
      cyc("k2_short3", i, (i < 3) ? 6'h3B : 6'h3F, 6'h00, 6'h00, 6'h00);
    // 3b: low for 4 samples -> count completes but pin reverses on the commit edge
    for (int i = 0; i < 12; i++)
      cyc("k2_short4", i, (i < 4) ? 6'h3B : 6'h3F, 6'h00, 6'h00, 6'h00);
    // 3c: low for 5 samples -> shortest accepted press; release commits 5 edges later
    for (int i = 0; i < 14; i++)
      cyc("k2_min", i, (i < 5) ? 6'h3B : 6'h3F,
          (i >= 6 && i < 11) ? 6'h04 : 6'h00,
          (i == 6) ? 6'h04 : 6'h00,
          (i == 11) ? 6'h04 : 6'h00);

    // 4: bouncy key 4: 0,0,1,0,1 then sustained 0 from index 5; released from index 12
    begin
      logic [9:0] pat;
      logic [5:0] r;
      pat = 10'b0000010100;  // bit i = raw value at index i
      for (int i = 0; i < 26; i++) begin
        if (i < 10)      r = pat[i] ? 6'h3F : 6'h2F;
        else if (i < 12) r = 6'h2F;
        else             r = 6'h3F;
        cyc("k4_bounce", i, r,
            (i >= 11 && i < 18) ? 6'h10 : 6'h00,
            (i == 11) ? 6'h10 : 6'h00,
            (i == 18) ? 6'h10 : 6'h00);
      end
    end

    // 5: keys 1 and 3 together
    for (int i = 0; i < 12; i++)
      cyc("k13_press", i, 6'h35, (i >= 6) ? 6'h0A : 6'h00, (i == 6) ? 6'h0A : 6'h00, 6'h00);
    for (int i = 0; i < 12; i++)
      cyc("k13_rel", i, 6'h3F, (i >= 6) ? 6'h00 : 6'h0A, 6'h00, (i == 6) ? 6'h0A : 6'h00);

    // 6: key 5 held; reset lands while CHK_P has cnt=3; debounce restarts after reset
    for (int i = 0; i < 5; i++) cyc("k5_pre", i, 6'h1F, 6'h00, 6'h00, 6'h00);
    rst = 1'b1;
    cyc("k5_rst", 0, 6'h1F, 6'h00, 6'h00, 6'h00);
    rst = 1'b0;
    for (int i = 0; i < 10; i++)
      cyc("k5_after", i, 6'h1F, (i >= 6) ? 6'h20 : 6'h00, (i == 6) ? 6'h20 : 6'h00, 6'h00);
    for (int i = 0; i < 12; i++)
      cyc("k5_rel", i, 6'h3F, (i >= 6) ? 6'h00 : 6'h20, 6'h00, (i == 6) ? 6'h20 : 6'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
